ospfb_power_acc: RTL

Downstream consumer of the OSPFB channelizer output. Takes the parallel complex spectrum stream (SAMP_PER_CLK bins per beat, FFT_LEN bins per frame, tlast on the final beat) and computes |X|² per bin. It accumulates those powers over ACC_LEN frames into a ping-pong bank pair, then streams each finished integrated spectrum out on an AXI-stream master while the other bank keeps integrating. It replaces the capture VIP in hardware builds.

---
 rtl/ospfb_power_acc.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ospfb_power_acc.sv
// Integrates |X|^2 per bin of the OSPFB spectrum over ACC_LEN frames in a ping-pong
// bank pair and streams each finished spectrum out on an AXI-stream master.
module ospfb_power_acc #(
  parameter int SAMP_PER_CLK = 2,
  parameter int FFT_LEN      = 64,
  parameter int WIDTH        = 16,
  parameter int ACC_LEN      = 8,
  parameter int ACC_W        = 48
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SAMP_PER_CLK*2*WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [SAMP_PER_CLK*ACC_W-1:0]   m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [15:0]                     m_axis_tuser,
  output logic                            framing_err,
  output logic                            sat_err
);
  localparam int BEATS = FFT_LEN / SAMP_PER_CLK;
  localparam int AW    = $clog2(BEATS);
  localparam int FW    = $clog2(ACC_LEN);
  localparam int PW    = 2 * WIDTH + 1;
  localparam int DW    = SAMP_PER_CLK * ACC_W;
  localparam int IW    = SAMP_PER_CLK * 2 * WIDTH;

  typedef enum logic {IN_ACC = 1'b0, IN_STALL = 1'b1} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_WAIT = 2'd1, OUT_DUMP = 2'd2} out_state_e;

  function automatic logic [PW-1:0] power_f(input logic signed [WIDTH-1:0] re,
                                            input logic signed [WIDTH-1:0] im);
    logic signed [2*WIDTH-1:0] rr;
    logic signed [2*WIDTH-1:0] ii;
    rr = (2*WIDTH)'(re) * (2*WIDTH)'(re);
    ii = (2*WIDTH)'(im) * (2*WIDTH)'(im);
    return PW'($unsigned(rr)) + PW'($unsigned(ii));
  endfunction

  // MSB of the result flags saturation; lower ACC_W bits are the clamped sum.
  function automatic logic [ACC_W:0] sat_add_f(input logic [ACC_W-1:0] a, input logic [PW-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(p);
    if (s[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end else begin
      return s;
    end
  endfunction

  logic [DW-1:0]  mem_q [2][BEATS];
  in_state_e      in_state_q;
  out_state_e     out_state_q;
  logic           tready_q, wr_bank_q, rd_bank_q, dump_req_q, ferr_q, sat_err_q;
  logic [AW-1:0]  b_q;
  logic [FW-1:0]  f_q;
  logic           s0_vld_q, s0_bank_q, s0_first_q;
  logic [IW-1:0]  s0_data_q;
  logic [AW-1:0]  s0_addr_q;
  logic           s1_vld_q, s1_bank_q, s1_first_q;
  logic [AW-1:0]  s1_addr_q;
  logic [SAMP_PER_CLK*PW-1:0] s1_p_q;
  logic [DW-1:0]  s1_acc_q;
  logic [AW:0]    raddr_q;
  logic           rvld_q, rlast_q, m_tvalid_q, m_tlast_q;
  logic [DW-1:0]  rdata_q, m_tdata_q;
  logic [15:0]    tuser_q;
  logic           accept_s, last_beat_s, end_frame_s, busy_s;
  logic           load_out_s, rd_en_s, wsat_s;
  logic [DW-1:0]  wdata_s;

  assign accept_s    = s_axis_tvalid && tready_q;
  assign last_beat_s = (b_q == AW'(BEATS - 1));
  assign end_frame_s = s_axis_tlast || last_beat_s;
  assign busy_s      = dump_req_q || (out_state_q != OUT_IDLE);

  // Input FSM, beat/frame counters and bank swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_q <= IN_ACC;
      tready_q   <= 1'b0;
      b_q        <= '0;
      f_q        <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      dump_req_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      if (dump_req_q && (out_state_q == OUT_IDLE)) begin
        dump_req_q <= 1'b0;
      end
      case (in_state_q)
        IN_ACC: begin
          tready_q <= 1'b1;
          if (accept_s) begin
            if (end_frame_s) begin
              b_q <= '0;
              if (s_axis_tlast != last_beat_s) begin
                ferr_q <= 1'b1;
              end
              if (f_q == FW'(ACC_LEN - 1)) begin
                f_q <= '0;
                if (busy_s) begin
                  in_state_q <= IN_STALL;
                  tready_q   <= 1'b0;
                end else begin
                  wr_bank_q  <= ~wr_bank_q;
                  rd_bank_q  <= wr_bank_q;
                  dump_req_q <= 1'b1;
                end
              end else begin
                f_q <= f_q + FW'(1);
              end
            end else begin
              b_q <= b_q + AW'(1);
            end
          end
        end
        IN_STALL: begin
          if (!busy_s) begin
            in_state_q <= IN_ACC;
            tready_q   <= 1'b1;
            wr_bank_q  <= ~wr_bank_q;
            rd_bank_q  <= wr_bank_q;
            dump_req_q <= 1'b1;
          end
        end
        default: in_state_q <= IN_ACC;
      endcase
    end
  end

  // Capture, power/read, then write; consecutive beats never alias so no forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld_q   <= 1'b0;
      s0_data_q  <= '0;
      s0_addr_q  <= '0;
      s0_bank_q  <= 1'b0;
      s0_first_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_bank_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_p_q     <= '0;
      s1_acc_q   <= '0;
      sat_err_q  <= 1'b0;
    end else begin
      s0_vld_q   <= accept_s;
      s0_data_q  <= s_axis_tdata;
      s0_addr_q  <= b_q;
      s0_bank_q  <= wr_bank_q;
      s0_first_q <= (f_q == '0);
      s1_vld_q   <= s0_vld_q;
      s1_addr_q  <= s0_addr_q;
      s1_bank_q  <= s0_bank_q;
      s1_first_q <= s0_first_q;
      s1_acc_q   <= mem_q[s0_bank_q][s0_addr_q];
      for (int k = 0; k < SAMP_PER_CLK; k++) begin
        s1_p_q[k*PW +: PW] <= power_f(s0_data_q[k*2*WIDTH +: WIDTH],
                                      s0_data_q[k*2*WIDTH+WIDTH +: WIDTH]);
      end
      if (s1_vld_q && wsat_s) begin
        sat_err_q <= 1'b1;
      end
    end
  end

  // Write-back data: overwrite on the first frame, saturating add otherwise.
  always_comb begin
    logic [ACC_W:0] sum_v;
    sum_v   = '0;
    wdata_s = '0;
    wsat_s  = 1'b0;
    for (int k = 0; k < SAMP_PER_CLK; k++) begin
      sum_v = sat_add_f(s1_acc_q[k*ACC_W +: ACC_W], s1_p_q[k*PW +: PW]);
      if (s1_first_q) begin
        wdata_s[k*ACC_W +: ACC_W] = ACC_W'(s1_p_q[k*PW +: PW]);
      end else begin
        wdata_s[k*ACC_W +: ACC_W] = sum_v[ACC_W-1:0];
        wsat_s = wsat_s | sum_v[ACC_W];
      end
    end
  end

  // Bank storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (s1_vld_q) begin
      mem_q[s1_bank_q][s1_addr_q] <= wdata_s;
    end
  end

  // Prefetch refills in the same cycle the output register takes its word.
  always_comb begin
    load_out_s = rvld_q && (!m_tvalid_q || m_axis_tready);
    rd_en_s    = (out_state_q == OUT_DUMP) && (raddr_q < (AW+1)'(BEATS)) &&
                 (!rvld_q || load_out_s);
  end

  // Output FSM; OUT_WAIT lets the final write of the swapped bank land before the first read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state_q <= OUT_IDLE;
      raddr_q     <= '0;
      rvld_q      <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      tuser_q     <= '0;
    end else begin
      if (rd_en_s) begin
        rdata_q <= mem_q[rd_bank_q][raddr_q[AW-1:0]];
        rlast_q <= (raddr_q == (AW+1)'(BEATS - 1));
        raddr_q <= raddr_q + (AW+1)'(1);
        rvld_q  <= 1'b1;
      end else if (load_out_s) begin
        rvld_q <= 1'b0;
      end
      if (load_out_s) begin
        m_tdata_q  <= rdata_q;
        m_tlast_q  <= rlast_q;
        m_tvalid_q <= 1'b1;
      end else if (m_tvalid_q && m_axis_tready) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
      case (out_state_q)
        OUT_IDLE: begin
          if (dump_req_q) begin
            out_state_q <= OUT_WAIT;
          end
        end
        OUT_WAIT: begin
          out_state_q <= OUT_DUMP;
          raddr_q     <= '0;
        end
        OUT_DUMP: begin
          if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
            out_state_q <= OUT_IDLE;
            tuser_q     <= tuser_q + 16'd1;
          end
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign framing_err   = ferr_q;
  assign sat_err       = sat_err_q;

endmodule
